// File: rtl/vga_pkg.sv
// Shared timing and geometry constants for the VGA controller.
// VRam and the scan generator both take VRAM_LAT from here.
package vga_pkg;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;

    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_SCALE  = 5;
    localparam int VGA_FB_W   = 128;
    localparam int VGA_FB_H   = 96;
    localparam int VGA_ADDR_W = 14;

    localparam int VGA_VRAM_LAT = 1;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sync_t;

    localparam sync_t SYNC_RST = '{
        hsync:    1'b1,
        vsync:    1'b1,
        video_on: 1'b0
    };

endpackage

// File: rtl/vga_scan_addr_if.sv
// Raster outputs of the scan generator: VRAM read address,
// aligned sync/blank and the frame marker.
interface vga_scan_addr_if
    import vga_pkg::*;
#(
    parameter int ADDR_W = VGA_ADDR_W
);

    logic [ADDR_W-1:0] addr;
    logic              hsync;
    logic              vsync;
    logic              video_on;
    logic              frame_start;

    modport master (
        output addr,
        output hsync,
        output vsync,
        output video_on,
        output frame_start
    );

    modport slave (
        input addr,
        input hsync,
        input vsync,
        input video_on,
        input frame_start
    );

endinterface

// File: rtl/vga_sync_delay.sv
// Shift register that holds sync and blank back by the VRam
// read latency so they meet the colour bits of the same pixel.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = VGA_VRAM_LAT
) (
    input  logic  clk,
    input  logic  rst,
    input  sync_t din,
    output sync_t dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_pipe
            sync_t pipe [DEPTH];

            // Shift sync/blank one stage per clk; idle level on reset
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        pipe[i] <= SYNC_RST;
                    end
                end else begin
                    pipe[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign dout = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_addr.sv
// Raster scan generator: 25 MHz pixel tick from 50 MHz clk,
// h/v timing, and divider-free VRAM address for a scaled frame buffer.
module vga_scan_addr
    import vga_pkg::*;
#(
    parameter int H_VIS    = VGA_H_VIS,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_VIS    = VGA_V_VIS,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int SCALE    = VGA_SCALE,
    parameter int FB_W     = VGA_FB_W,
    parameter int FB_H     = VGA_FB_H,
    parameter int ADDR_W   = VGA_ADDR_W,
    parameter int VRAM_LAT = VGA_VRAM_LAT
) (
    input  logic            clk,
    input  logic            rst,
    vga_scan_addr_if.master vo
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int CW    = (FB_W > 1) ? $clog2(FB_W) : 1;

    localparam logic [HW-1:0] H_ONE   = HW'(1);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VEND  = HW'(H_VIS);
    localparam logic [HW-1:0] H_CLAST = HW'(H_VIS - 1);
    localparam logic [HW-1:0] H_SBEG  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] H_SEND  = HW'(H_VIS + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_ONE   = VW'(1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VEND  = VW'(V_VIS);
    localparam logic [VW-1:0] V_SBEG  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] V_SEND  = VW'(V_VIS + V_FP + V_SYNC);

    localparam logic [SW-1:0] S_ONE   = SW'(1);
    localparam logic [SW-1:0] S_LAST  = SW'(SCALE - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(FB_W * FB_H - 1);

    logic              pix_tick;
    logic [HW-1:0]     h_cnt, h_nxt;
    logic [VW-1:0]     v_cnt, v_nxt;
    logic [SW-1:0]     sub_x, sx_nxt;
    logic [SW-1:0]     sub_y, sy_nxt;
    logic [CW-1:0]     col, col_nxt;
    logic [ADDR_W-1:0] row_base, rb_nxt;
    logic [ADDR_W-1:0] addr_q, addr_sum, addr_nxt;
    logic              vis_nxt;
    sync_t             raw_s, dly_s;

    // Pixel tick: high on every other clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= ~pix_tick;
        end
    end

    // Next raster and scaling counters; only move on pix_tick
    always_comb begin
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        sx_nxt  = sub_x;
        col_nxt = col;
        sy_nxt  = sub_y;
        rb_nxt  = row_base;
        if (pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_nxt   = '0;
                sx_nxt  = '0;
                col_nxt = '0;
                if (v_cnt == V_LAST) begin
                    v_nxt  = '0;
                    sy_nxt = '0;
                    rb_nxt = '0;
                end else begin
                    v_nxt = v_cnt + V_ONE;
                    if (v_cnt < V_VEND) begin
                        if (sub_y == S_LAST) begin
                            sy_nxt = '0;
                            rb_nxt = row_base + ROW_STEP;
                        end else begin
                            sy_nxt = sub_y + S_ONE;
                        end
                    end
                end
            end else begin
                h_nxt = h_cnt + H_ONE;
                if (h_cnt < H_CLAST) begin
                    if (sub_x == S_LAST) begin
                        sx_nxt  = '0;
                        col_nxt = col + C_ONE;
                    end else begin
                        sx_nxt = sub_x + S_ONE;
                    end
                end
            end
        end
    end

    // Address for the pixel the counters will point at next
    always_comb begin
        vis_nxt  = (h_nxt < H_VEND) && (v_nxt < V_VEND);
        addr_sum = rb_nxt + ADDR_W'(col_nxt);
        addr_nxt = '0;
        if (vis_nxt && (addr_sum <= ADDR_MAX)) begin
            addr_nxt = addr_sum;
        end
    end

    // Counter and address registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            sub_x    <= '0;
            col      <= '0;
            sub_y    <= '0;
            row_base <= '0;
            addr_q   <= '0;
        end else begin
            h_cnt    <= h_nxt;
            v_cnt    <= v_nxt;
            sub_x    <= sx_nxt;
            col      <= col_nxt;
            sub_y    <= sy_nxt;
            row_base <= rb_nxt;
            addr_q   <= addr_nxt;
        end
    end

    // Undelayed sync and blank decoded from the current counters
    always_comb begin
        raw_s.hsync    = ~((h_cnt >= H_SBEG) && (h_cnt < H_SEND));
        raw_s.vsync    = ~((v_cnt >= V_SBEG) && (v_cnt < V_SEND));
        raw_s.video_on = (h_cnt < H_VEND) && (v_cnt < V_VEND);
    end

    vga_sync_delay #(
        .DEPTH (VRAM_LAT)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (raw_s),
        .dout (dly_s)
    );

    assign vo.addr        = addr_q;
    assign vo.hsync       = dly_s.hsync;
    assign vo.vsync       = dly_s.vsync;
    assign vo.video_on    = dly_s.video_on;
    assign vo.frame_start = pix_tick & (h_cnt == '0) & (v_cnt == '0);

endmodule

// File: tb/tb_vga_scan_addr.sv
// Scoreboard bench: full-size and shrunken-raster instances checked
// against a pixel-index reference model across random resets.
module tb_vga_scan_addr;

    typedef struct {
        int addr;
        bit hs;
        bit vs;
        bit von;
        bit fs;
    } obs_t;

    typedef struct {
        int   e;
        obs_t f;
        obs_t s;
    } exp_t;

    logic clk;
    logic rst;
    int   e;
    int   n_chk;
    int   n_pass;
    exp_t sb [$];

    vga_scan_addr_if #(.ADDR_W(14)) bf ();
    vga_scan_addr_if #(.ADDR_W(14)) bs ();

    vga_scan_addr u_full (
        .clk (clk),
        .rst (rst),
        .vo  (bf)
    );

    vga_scan_addr #(
        .H_VIS  (40),
        .H_FP   (4),
        .H_SYNC (8),
        .H_BP   (4),
        .V_VIS  (20),
        .V_FP   (2),
        .V_SYNC (2),
        .V_BP   (3)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .vo  (bs)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Undelayed view after e clk edges since reset release:
    // pixel index is e/2, position follows from plain division.
    function automatic obs_t raw(input int e,
                                 input int hv, input int hfp,
                                 input int hsy, input int hbp,
                                 input int vv, input int vfp,
                                 input int vsy, input int vbp);
        int   a;
        int   ht;
        int   vt;
        int   h;
        int   v;
        obs_t o;
        a  = e / 2;
        ht = hv + hfp + hsy + hbp;
        vt = vv + vfp + vsy + vbp;
        h  = a % ht;
        v  = (a / ht) % vt;
        o.von  = (h < hv) && (v < vv);
        o.addr = o.von ? (v / 5) * 128 + h / 5 : 0;
        o.hs   = !((h >= hv + hfp) && (h < hv + hfp + hsy));
        o.vs   = !((v >= vv + vfp) && (v < vv + vfp + vsy));
        o.fs   = (e % 2 == 1) && (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic obs_t model(input int e,
                                   input int hv, input int hfp,
                                   input int hsy, input int hbp,
                                   input int vv, input int vfp,
                                   input int vsy, input int vbp);
        obs_t now;
        obs_t prv;
        now = raw(e, hv, hfp, hsy, hbp, vv, vfp, vsy, vbp);
        if (e == 0) begin
            prv.hs  = 1'b1;
            prv.vs  = 1'b1;
            prv.von = 1'b0;
        end else begin
            prv = raw(e - 1, hv, hfp, hsy, hbp, vv, vfp, vsy, vbp);
        end
        now.hs  = prv.hs;
        now.vs  = prv.vs;
        now.von = prv.von;
        return now;
    endfunction

    function automatic exp_t expect_at(input int e);
        exp_t x;
        x.e = e;
        x.f = model(e, 640, 16, 96, 48, 480, 10, 2, 33);
        x.s = model(e, 40, 4, 8, 4, 20, 2, 2, 3);
        return x;
    endfunction

    task automatic chk(input string nm, input int e,
                       input int got, input int want);
        n_chk++;
        if (got == want) begin
            n_pass++;
        end else begin
            $display("FAIL %s e=%0d got %0d expected %0d",
                     nm, e, got, want);
        end
    endtask

    // One clk of stimulus; reset edges land mid-cycle
    task automatic cycle(input bit do_assert, input bit do_release);
        @(posedge clk);
        if (rst) e++;
        else e = 0;
        #3;
        if (do_assert) begin
            rst = 1'b0;
            e   = 0;
        end
        if (do_release) rst = 1'b1;
        sb.push_back(expect_at(e));
    endtask

    // Monitor: pop one expectation per clk and compare
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() == 0) begin
            chk("queue_empty", e, 0, 1);
        end else begin
            x = sb.pop_front();
            chk("full.addr",  x.e, int'(bf.addr),        x.f.addr);
            chk("full.hsync", x.e, int'(bf.hsync),       int'(x.f.hs));
            chk("full.vsync", x.e, int'(bf.vsync),       int'(x.f.vs));
            chk("full.von",   x.e, int'(bf.video_on),    int'(x.f.von));
            chk("full.fs",    x.e, int'(bf.frame_start), int'(x.f.fs));
            chk("full.range", x.e, int'(bf.addr <= 14'd12287), 1);
            chk("small.addr",  x.e, int'(bs.addr),        x.s.addr);
            chk("small.hsync", x.e, int'(bs.hsync),       int'(x.s.hs));
            chk("small.vsync", x.e, int'(bs.vsync),       int'(x.s.vs));
            chk("small.von",   x.e, int'(bs.video_on),    int'(x.s.von));
            chk("small.fs",    x.e, int'(bs.frame_start), int'(x.s.fs));
            chk("small.range", x.e, int'(bs.addr <= 14'd12287), 1);
        end
    end

    initial begin
        int run;
        int hold;
        n_chk  = 0;
        n_pass = 0;
        e      = 0;
        rst    = 1'b1;
        #1 rst = 1'b0;
        repeat (5) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            run  = $urandom_range(9000, 15000);
            hold = $urandom_range(1, 4);
            repeat (run) cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
            repeat (hold) cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b1);
        end
        repeat (4000) cycle(1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", e, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_scan_addr.md
# vga_scan_addr

- Raster scan generator and VRAM read initiator for the VGA controller.
- Runs on the 50 MHz system clock and derives a 25 MHz pixel tick internally.
- Produces standard 640x480@60 sync timing and drives the 14-bit VRAM read address, upscaling a 128x96 frame buffer by 5 in both axes.
- Sync and blanking outputs are delayed to line up with the colour bits returned by VRam.

## Interface
Parameters:
- H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48 — horizontal pixel counts (total 800)
- V_VIS 480, V_FP 10, V_SYNC 2, V_BP 33 — vertical line counts (total 525)
- SCALE 5 — pixel replication factor per axis
- FB_W 128, FB_H 96 — frame-buffer geometry
- ADDR_W 14 — VRAM address width
- VRAM_LAT 1 — VRam read latency in clk cycles

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-low
- addr  out  ADDR_W  VRAM read address, to VRam addr
- hsync  out  1  horizontal sync, active-low, aligned to VRam colour output
- vsync  out  1  vertical sync, active-low, aligned to VRam colour output
- video_on  out  1  high while the aligned pixel is visible; downstream gates red/green/blue with it
- frame_start  out  1  one-clk pulse on the first clk of pixel (0,0), undelayed

## Operation
- pix_tick toggles every clk and is 1 on alternate clks; all raster counters advance only when pix_tick=1.
- h_cnt counts 0..799 and wraps to 0. When it wraps, v_cnt advances, counting 0..524 and wrapping to 0.
- Visible region: h_cnt<640 and v_cnt<480.
- Raw hsync is low for h_cnt 656..751. Raw vsync is low for v_cnt 490..491.
- Address uses no divider:
  - sub_x counts 0..SCALE-1 and advances col (0..127) on wrap.
  - sub_y counts 0..SCALE-1 and advances row_base by FB_W on wrap.
  - addr = row_base + col.
- col and sub_x clear at h_cnt=0. row_base and sub_y clear at v_cnt=0.
- sub_y and row_base advance once per line, at the h_cnt 799->0 transition, only while v_cnt<480.
- Outside the visible region, addr is 0.
- Address range is 0..12287; addr never exceeds FB_W*FB_H-1.
- Reset mid-frame returns all counters to 0 asynchronously. Scanning restarts at pixel (0,0) on the first pix_tick after release.

## Timing
- Reset values: addr=0, hsync=1, vsync=1, video_on=0, frame_start=0, pix_tick=0, all counters 0.
- Each pixel lasts 2 clks. addr is registered and changes on the clk edge where the counters advance.
- hsync, vsync and video_on pass through a VRAM_LAT-deep register pipeline, so they coincide with the VRam colour bits for the same pixel. addr is not delayed.
- frame_start is asserted for exactly one clk, every 840000 clks (800*525*2). The first pulse comes on the first counting clk after reset release.
- Line period is 1600 clks. Each frame-buffer column is held for 10 clks. Each frame-buffer row is repeated for 5 lines.
- Simultaneous h and v wrap at (799,524): all counters return to 0 on the same tick, and frame_start asserts.

## Structure
- Shared package `vga_pkg`:
  - 640x480@60 timing constants
  - SCALE, FB_W, FB_H, ADDR_W
  - VRAM_LAT, so VRam and this block agree
- One sub-module, `vga_sync_delay`: a parameterised VRAM_LAT-stage shift register for {hsync, vsync, video_on}. Its reset value is {1,1,0}.
- Everything else lives in the top block: tick, h/v counters, scaling counters, address register.

## Test plan
- Hold rst=0 for 100 ns -> addr=0, hsync=1, vsync=1, video_on=0, frame_start=0. Release rst -> frame_start pulses once.
- First line -> addr is 0 for 10 clks, then 1 for 10 clks, and reaches 127 at h_cnt 635..639. addr=0 from h_cnt 640. video_on falls one clk after h_cnt reaches 640.
- Horizontal sync -> hsync low for exactly 192 clks, starting 1312+VRAM_LAT clks after line start. Line period measured at 1600 clks.
- Vertical scaling:
  - lines 0..4 start at addr 0
  - line 5 starts at addr 128
  - line 475 starts at addr 12160
  - last visible pixel shows addr 12287
  - vsync low for 3200 clks, covering lines 490..491
- Assert rst at h_cnt 300, v_cnt 200 for 3 clks -> outputs take reset values immediately, asynchronously. After release, addr sequence restarts at 0 and the next frame_start comes 840000 clks after the post-release pulse.
- Two full frames -> exactly two frame_start pulses 840000 clks apart, no addr value above 12287, and 480 visible lines per frame.
